afifo_write_arbiter: RTL
========================

Name: afifo_write_arbiter

Overview:
- Shares the write port of one AFIFO instance between NReq producers in the write-clock domain.
- Round-robin arbitration at burst granularity. A grant is held until the requester's last word or until MaxBurst words have been written, whichever comes first.
- Drives AFIFO w/wd directly and honours wfull. The read side of the FIFO is untouched.

Parameters:
- Width, 12, data word width; must equal the AFIFO Width.
- NReq, 4, number of requesters (2..8).
- MaxBurst, 16, maximum words per grant before forced release (>=1).

Ports:
- clk  in  1  write-domain clock (same net as AFIFO wclk)
- rst  in  1  asynchronous reset, active-high
- req  in  NReq  per-requester word-valid; bit i = requester i has a word on reqData
- reqLast  in  NReq  bit i marks requester i's current word as the last of its burst
- reqData  in  NReq*Width  flattened data; requester i occupies bits [i*Width +: Width]
- ack  out  NReq  one-hot pulse; requester i's word was written this cycle
- grant  out  NReq  one-hot current grant; all-zero when idle
- w  out  1  AFIFO write strobe
- wd  out  Width  AFIFO write data
- wfull  in  1  AFIFO full flag (registered in the write domain)
- busy  out  1  high whenever a grant is held

Behaviour:
- Reset (async, any time): state=IDLE, grant=0, ack=0, w=0, busy=0, wordCount=0, rrPtr=0.
  - wd follows the reqData mux and is don't-care while w=0.
  - Words already written to the FIFO stay there.
- Internal state: two states, IDLE and GRANT.
  - rrPtr is $clog2(NReq) bits; wordCount is $clog2(MaxBurst+1) bits.
- IDLE:
  - w=0.
  - If any req bit is set, select the first set bit scanning rrPtr, rrPtr+1, ... modulo NReq.
  - Register the one-hot grant, clear wordCount, go to GRANT next cycle.
  - If req=0, stay in IDLE.
- GRANT, granted index g:
  - w = req[g], combinational.
  - wd = reqData slice g, combinational.
  - accept = w & !wfull.
  - ack[g] = accept, all other ack bits 0.
  - On accept, wordCount increments.
- GRANT exit:
  - Leave on accept & (reqLast[g] | wordCount==MaxBurst-1).
  - Leave if req[g]==0, which abandons the burst; no ack in that cycle.
  - Either way: next state IDLE, grant cleared, rrPtr = (g+1) mod NReq.
- Latency:
  - req rising in IDLE at cycle 0: grant at cycle 1; first word can be written at cycle 1.
  - Exactly one dead (IDLE) cycle between consecutive grants, even when requests are back-to-back.
- wfull:
  - While wfull=1: w stays asserted, no ack, wordCount frozen, grant held.
  - A burst never loses its grant because of back-pressure.
- Simultaneous events:
  - reqLast together with wordCount==MaxBurst-1 is a single release, not a double increment.
  - req bits changing for non-granted requesters while in GRANT are ignored until IDLE.
- Throughput: at most one word per clk.
  - A requester must hold reqData/reqLast stable while req is high until ack.

Optional Feature:
- Macro AFIFO_ARB_STATS_EN.
- Defined:
  - Adds output statWords (NReq*16): per-requester saturating count of acked words; saturates at 16'hFFFF.
  - Adds output statStalls (16): saturating count of cycles with w & wfull.
  - Adds input statClr (1): synchronous clear of all statistics; it has priority over a same-cycle increment.
  - All statistics reset to 0 on rst.
- Undefined: none of these ports or registers exist, and core behaviour is identical.

Test Plan:
- Single requester 0, 5-word burst (data 0x000..0x004, reqLast on 0x004), wfull=0 -> grant=0001 at cycle 1; ack on cycles 1..5; FIFO holds 0x000..0x004; IDLE at cycle 6.
- All 4 requesting 20-word bursts continuously, MaxBurst=16 -> grant order 0,1,2,3,0,...; each grant acks exactly 16 words, then the remaining 4; one idle cycle between grants.
- wfull forced high for 3 cycles mid-burst after word 2 -> w stays 1, ack stays 0 for 3 cycles; burst resumes at word 3 with no loss or duplication; grant unchanged.
- Requester 2 drops req after 1 of 4 words -> release to IDLE next cycle, rrPtr=3; requester 3 is granted before requester 2 on re-request.
- rst asserted mid-burst between clock edges -> grant, ack, w, busy go 0 immediately; after deassert, the first grant goes to requester 0 when all requesters are active.
- AFIFO_ARB_STATS_EN: requester 1 writes 10 words with 4 full-stall cycles -> statWords[1]=10, statStalls=4; statClr for one cycle -> all counts 0.

Source files
------------

// File: rtl/afifo_write_arbiter.sv
//------------------------------------------------------------------------------
// Module  : afifo_write_arbiter
// Brief   : Burst-granular round-robin arbiter that shares one AFIFO write
//           port between NReq producers in the write-clock domain. A grant is
//           held until the requester's last word, MaxBurst words, or the
//           requester dropping req. Back-pressure (wfull) never costs a grant.
// Options : AFIFO_ARB_STATS_EN adds per-requester word counters, a stall
//           counter and a synchronous statistics clear.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module afifo_write_arbiter #(
  parameter int Width    = 12,
  parameter int NReq     = 4,
  parameter int MaxBurst = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NReq-1:0]         req,
  input  logic [NReq-1:0]         reqLast,
  input  logic [NReq*Width-1:0]   reqData,
  output logic [NReq-1:0]         ack,
  output logic [NReq-1:0]         grant,
  output logic                    w,
  output logic [Width-1:0]        wd,
  input  logic                    wfull,
  output logic                    busy
`ifdef AFIFO_ARB_STATS_EN
  ,
  input  logic                    statClr,
  output logic [NReq*16-1:0]      statWords,
  output logic [15:0]             statStalls
`endif
);

  localparam int c_PtrW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int c_CntW = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
  localparam logic [c_CntW-1:0] c_LastCnt = c_CntW'(MaxBurst - 1);
  localparam logic [c_PtrW-1:0] c_TopIdx  = c_PtrW'(NReq - 1);
  localparam logic [NReq-1:0]   c_OneHot0 = {{(NReq-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic [NReq-1:0]     r_grant;
  logic [c_PtrW-1:0]   r_gidx;
  logic [c_PtrW-1:0]   r_rrPtr;
  logic [c_CntW-1:0]   r_wordCount;
  logic                r_busy;

  logic                w_found;
  logic [c_PtrW-1:0]   w_pick;
  logic                w_gReq;
  logic                w_gLast;
  logic                w_accept;
  logic                w_burstEnd;
  logic [c_PtrW-1:0]   w_nextPtr;

  // Round-robin search: first requesting index starting at rrPtr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NReq; k++) begin
      if (!w_found && req[c_PtrW'((int'(r_rrPtr) + k) % NReq)]) begin
        w_found = 1'b1;
        w_pick  = c_PtrW'((int'(r_rrPtr) + k) % NReq);
      end
    end
  end

  // Write path is a direct mux of the granted requester; the FIFO sees it
  // in the same cycle so one word per clock is possible.
  assign w_gReq     = req[r_gidx];
  assign w_gLast    = reqLast[r_gidx];
  assign w          = (r_state == S_GRANT) & w_gReq;
  assign wd         = reqData[r_gidx*Width +: Width];
  assign w_accept   = w & ~wfull;
  assign ack        = w_accept ? r_grant : '0;
  assign w_burstEnd = w_gLast | (r_wordCount == c_LastCnt);
  assign w_nextPtr  = (r_gidx == c_TopIdx) ? '0 : r_gidx + 1'b1;
  assign grant      = r_grant;
  assign busy       = r_busy;

  // Arbitration FSM: IDLE picks a winner, GRANT serves it until release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_rrPtr     <= '0;
      r_wordCount <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_GRANT;
            r_grant     <= c_OneHot0 << w_pick;
            r_gidx      <= w_pick;
            r_wordCount <= '0;
            r_busy      <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!w_gReq) begin
            // Requester abandoned its burst; release without a write.
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_rrPtr <= w_nextPtr;
          end else if (w_accept) begin
            // Last word and burst cap together are a single release.
            r_wordCount <= r_wordCount + 1'b1;
            if (w_burstEnd) begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_rrPtr <= w_nextPtr;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AFIFO_ARB_STATS_EN
  logic [15:0] r_statStalls;

  generate
    for (genvar gi = 0; gi < NReq; gi++) begin : g_stat_words
      logic [15:0] r_words;

      // Saturating count of words accepted for this requester.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_words <= '0;
        end else if (statClr) begin
          r_words <= '0;
        end else if (ack[gi] && (r_words != 16'hFFFF)) begin
          r_words <= r_words + 16'd1;
        end
      end

      assign statWords[gi*16 +: 16] = r_words;
    end
  endgenerate

  // Saturating count of cycles where a write was held off by wfull.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statStalls <= '0;
    end else if (statClr) begin
      r_statStalls <= '0;
    end else if (w && wfull && (r_statStalls != 16'hFFFF)) begin
      r_statStalls <= r_statStalls + 16'd1;
    end
  end

  assign statStalls = r_statStalls;
`endif

endmodule

`default_nettype wire
